// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter that owns a shared WIDTH-bit storage register.
// Each write is sequenced IDLE -> GRANT -> COMMIT, one requester at a time.
module dff_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] d_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  wr_en,
    output logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      q,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        COMMIT
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   pick;
    logic [NREQ-1:0] pick_oh;
    logic            found;
    logic [WIDTH-1:0] win_data;

    // First set request bit at or after ptr, wrapping modulo NREQ.
    always_comb begin
        logic [PW-1:0] cidx;
        found   = 1'b0;
        pick    = '0;
        pick_oh = '0;
        cidx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cidx = PW'((32'(ptr) + k) % 32'(NREQ));
            if (!found && req[cidx]) begin
                found         = 1'b1;
                pick          = cidx;
                pick_oh[cidx] = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                win_data = d_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            wr_en   <= 1'b0;
            wr_data <= '0;
            q       <= '0;
            ptr     <= '0;
            win     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt   <= '0;
                    wr_en <= 1'b0;
                    if (found) begin
                        gnt   <= pick_oh;
                        win   <= pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    gnt <= '0;
                    // A withdrawn request aborts without touching ptr.
                    if (req[win]) begin
                        wr_data <= win_data;
                        wr_en   <= 1'b1;
                        state   <= COMMIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                COMMIT: begin
                    q     <= wr_data;
                    wr_en <= 1'b0;
                    ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    wr_en <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed bench for dff_write_arbiter: write data is queued when requested
// and compared when wr_en appears; q is compared on the following cycle.
module tb_dff_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] d_in;
    logic [NREQ-1:0]       gnt;
    logic                  wr_en;
    logic [WIDTH-1:0]      wr_data;
    logic [WIDTH-1:0]      q;
    logic                  busy;

    int n_cmp;
    int n_err;

    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] q_exp;
    logic             q_pending;

    dff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d_in    (d_in),
        .gnt     (gnt),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .q       (q),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; then score any write strobe and the q update it implies.
    task automatic tick();
        logic [WIDTH-1:0] e;
        @(posedge clk);
        #1;
        chk("gnt_wr_excl", 32'(((|gnt) && wr_en) ? 1 : 0), 32'd0);
        chk("gnt_onehot0", 32'($onehot0(gnt) ? 1 : 0), 32'd1);
        if (q_pending) begin
            chk("q_after_commit", 32'(q), 32'(q_exp));
            q_pending = 1'b0;
        end
        if (wr_en) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_empty: observed write %0h expected none", wr_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_data", 32'(wr_data), 32'(e));
                q_exp     = e;
                q_pending = 1'b1;
            end
        end
    endtask

    task automatic set_d(input int i, input logic [WIDTH-1:0] v);
        d_in[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        q_pending = 1'b0;
        q_exp     = '0;
        rst_n     = 1'b0;
        req       = '0;
        d_in      = '0;

        // Reset state
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester, latency and ptr
        req = 4'b0100;
        set_d(2, 8'hA5);
        sb.push_back(8'hA5);
        tick();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_wr_c1", 32'(wr_en), 32'd0);
        tick();
        chk("single_wr_en", 32'(wr_en), 32'd1);
        chk("single_gnt_c2", 32'(gnt), 32'd0);
        req = '0;
        tick();
        chk("single_q", 32'(q), 32'hA5);
        chk("single_ptr", 32'(dut.ptr), 32'd3);
        chk("single_idle", 32'(busy), 32'd0);

        // Simultaneous requests held from reset, with pointer wrap
        rst_n = 1'b0;
        req   = 4'b1010;
        set_d(1, 8'h21);
        set_d(3, 8'h43);
        #1;
        chk("rst2_q", 32'(q), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.push_back(8'h21);
        sb.push_back(8'h43);
        tick();
        chk("simul_gnt1", 32'(gnt), 32'h2);
        tick();
        req = 4'b1000;
        tick();
        tick();
        chk("simul_gnt2", 32'(gnt), 32'h8);
        tick();
        req = '0;
        tick();
        chk("simul_q", 32'(q), 32'h43);
        chk("simul_ptr_wrap", 32'(dut.ptr), 32'd0);

        // Continuous contention, fairness and 3-cycle spacing
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_d(i, 8'(8'h10 + i));
        for (int g = 0; g < 5; g++) sb.push_back(8'(8'h10 + (g % NREQ)));
        for (int g = 0; g < 5; g++) begin
            tick();
            chk($sformatf("rr_gnt%0d", g), 32'(gnt), 32'(1 << (g % NREQ)));
            tick();
            chk($sformatf("rr_gap_a%0d", g), 32'(gnt), 32'd0);
            tick();
            chk($sformatf("rr_gap_b%0d", g), 32'(gnt), 32'd0);
        end
        req = '0;
        chk("rr_q_final", 32'(q), 32'h10);
        chk("rr_ptr", 32'(dut.ptr), 32'd1);

        // Reset asserted during COMMIT discards the pending write
        req = 4'b0010;
        set_d(1, 8'h3C);
        sb.push_back(8'h3C);
        tick();
        chk("mid_gnt", 32'(gnt), 32'h2);
        tick();
        chk("mid_wr_en", 32'(wr_en), 32'd1);
        req = '0;
        #2;
        rst_n = 1'b0;
        #1;
        q_pending = 1'b0;
        chk("mid_rst_q", 32'(q), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("mid_q_stays", 32'(q), 32'd0);
        chk("mid_ptr", 32'(dut.ptr), 32'd0);

        // Abort: request withdrawn during GRANT
        req = 4'b0001;
        set_d(0, 8'h77);
        tick();
        chk("abort_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_gnt_off", 32'(gnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        tick();
        chk("abort_wr_en2", 32'(wr_en), 32'd0);
        chk("abort_q", 32'(q), 32'd0);
        chk("abort_ptr", 32'(dut.ptr), 32'd0);

        // Late arrival during COMMIT waits for IDLE
        req = 4'b0001;
        set_d(0, 8'h5A);
        sb.push_back(8'h5A);
        sb.push_back(8'h6B);
        tick();
        chk("late_gnt0", 32'(gnt), 32'h1);
        tick();
        req = 4'b0010;
        set_d(1, 8'h6B);
        tick();
        chk("late_no_early_gnt", 32'(gnt), 32'd0);
        tick();
        chk("late_gnt1", 32'(gnt), 32'h2);
        tick();
        req = '0;
        tick();
        chk("late_q", 32'(q), 32'h6B);
        chk("late_ptr", 32'(dut.ptr), 32'd2);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
